vga_scan_engine: RTL and testbench

//  Parametrised VGA raster timing generator with image-window readout. Produces H/V sync, data-enable,

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_scan_engine_if.sv | 15 +
 rtl/vga_delay_line.sv | 16 +
 rtl/vga_scan_engine.sv | 138 +++++++++++++
 tb/tb_vga_scan_engine.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: VGA timing presets, colour constants and the pipeline sideband type
package vga_pkg;
   typedef struct packed {
      int   h_disp, h_front, h_sync, h_back;
      int   v_disp, v_front, v_sync, v_back;
      logic hs_pol, vs_pol;
   } timing_t;
   localparam timing_t T_1280X1024 = '{1280, 48, 112, 248, 1024, 1, 3, 38, 1'b1, 1'b1};
   localparam timing_t T_640X480 = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
   localparam int PKG_CW = 12;
   typedef logic [PKG_CW-1:0] rgb_t;
   localparam rgb_t BLACK = 12'h000;
   localparam rgb_t RED = 12'hF00;
   localparam rgb_t GREEN = 12'h0F0;
   localparam rgb_t BLUE = 12'h00F;
   localparam rgb_t YELLOW = 12'hFF0;
   localparam rgb_t MAGENTA = 12'hF0F;
   localparam rgb_t CYAN = 12'h0FF;
   localparam rgb_t WHITE = 12'hFFF;
   // {r,g,b} on/off per bar, bar 0 in the low slot: white,red,magenta,yellow,green,blue,cyan,black
   localparam logic [7:0][2:0] BAR_CODE = {3'b000, 3'b011, 3'b001, 3'b010, 3'b110, 3'b101, 3'b100, 3'b111};
   typedef struct packed {
      logic        fs, de, win, hs, vs;
      logic [10:0] x, y;
   } side_t;
endpackage

// File: rtl/vga_scan_engine_if.sv
// vga_scan_engine_if: ROM port, background/test controls and VGA pin bundle of the scan engine
interface vga_scan_engine_if #(parameter int AW = 16, parameter int CW = 12);
   logic [AW-1:0] img_addr;
   logic [CW-1:0] img_data, bg_rgb, vga_rgb;
   logic          test_en, vga_hsync, vga_vsync, vga_de, frame_start;
   logic [10:0]   pix_x, pix_y;
   modport master (
      input  img_data, bg_rgb, test_en,
      output img_addr, vga_hsync, vga_vsync, vga_de, vga_rgb, pix_x, pix_y, frame_start
   );
   modport slave (
      output img_data, bg_rgb, test_en,
      input  img_addr, vga_hsync, vga_vsync, vga_de, vga_rgb, pix_x, pix_y, frame_start
   );
endinterface

// File: rtl/vga_delay_line.sv
// vga_delay_line: W-bit, D-stage shift register with async active-low clear
module vga_delay_line #(parameter int W = 1, parameter int D = 1) (
   input  logic         clk_vga,
   input  logic         RST_N,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);
   logic [D-1:0][W-1:0] r_sr;
   always_ff @(posedge clk_vga or negedge RST_N)
      if (!RST_N) r_sr <= '0;
      else begin
         r_sr[0] <= i_d;
         for (int i = 1; i < D; i++) r_sr[i] <= r_sr[i-1];
      end
   assign o_q = r_sr[D-1];
endmodule

// File: rtl/vga_scan_engine.sv
// vga_scan_engine: VGA raster timing with a ROM-backed image window, sidebands delay-matched to ROM latency
// Defining VGA_TESTBAR_EN adds an 8-bar colour test pattern selected by test_en.
module vga_scan_engine
   import vga_pkg::*;
#(
   parameter int H_DISP = T_1280X1024.h_disp,
   parameter int H_FRONT = T_1280X1024.h_front,
   parameter int H_SYNC = T_1280X1024.h_sync,
   parameter int H_BACK = T_1280X1024.h_back,
   parameter int V_DISP = T_1280X1024.v_disp,
   parameter int V_FRONT = T_1280X1024.v_front,
   parameter int V_SYNC = T_1280X1024.v_sync,
   parameter int V_BACK = T_1280X1024.v_back,
   parameter bit HS_POL = 1'b1,
   parameter bit VS_POL = 1'b1,
   parameter int IMG_X0 = 0,
   parameter int IMG_Y0 = 0,
   parameter int IMG_W = 256,
   parameter int IMG_H = 256,
   parameter int SCALE_LOG2 = 0,
   parameter int ROM_LAT = 2,
   parameter int AW = 16,
   parameter int CW = 12
) (
   input  logic              clk_vga,
   input  logic              RST_N,
   vga_scan_engine_if.master bus
);
   localparam int H_TOTAL = H_DISP + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISP + V_FRONT + V_SYNC + V_BACK;
   localparam int HS_BEG = H_DISP + H_FRONT;
   localparam int VS_BEG = V_DISP + V_FRONT;
   localparam int WIN_W = IMG_W << SCALE_LOG2;
   localparam int WIN_H = IMG_H << SCALE_LOG2;
   localparam int SUB = (1 << SCALE_LOG2) - 1;
   localparam int C = CW / 3;
   if (ROM_LAT < 1 || ROM_LAT > 4) begin : g_chk_lat
      $error("ROM_LAT must be 1..4");
   end
   if (SCALE_LOG2 < 0 || SCALE_LOG2 > 2) begin : g_chk_scale
      $error("SCALE_LOG2 must be 0..2");
   end
   if (CW % 3 != 0) begin : g_chk_cw
      $error("CW must be a multiple of 3");
   end
   if (longint'(IMG_W) * IMG_H > (longint'(1) << AW)) begin : g_chk_aw
      $error("IMG_W*IMG_H exceeds ROM address space");
   end
   if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_chk_tot
      $error("raster totals exceed 11-bit counters");
   end
   logic [10:0]   r_hcnt, r_vcnt;
   logic [AW-1:0] r_col, r_row, r_addr;
   logic [1:0]    r_xs, r_ys;
   int            w_h, w_v;
   logic          w_eol, w_eof, w_active, w_win_row, w_win;
   side_t         w_s0, w_sd;
   logic [CW-1:0] w_pix;
   always_comb begin
      w_h = int'(r_hcnt);
      w_v = int'(r_vcnt);
      w_eol = w_h == H_TOTAL - 1;
      w_eof = w_eol && w_v == V_TOTAL - 1;
      w_active = w_h < H_DISP && w_v < V_DISP;
      w_win_row = w_v < V_DISP && w_v >= IMG_Y0 && w_v < IMG_Y0 + WIN_H;
      w_win = w_active && w_win_row && w_h >= IMG_X0 && w_h < IMG_X0 + WIN_W;
      w_s0.fs = w_active && w_h == 0 && w_v == 0;
      w_s0.de = w_active;
      w_s0.win = w_win;
      w_s0.hs = w_h >= HS_BEG && w_h < HS_BEG + H_SYNC;
      w_s0.vs = w_v >= VS_BEG && w_v < VS_BEG + V_SYNC;
      w_s0.x = w_active ? r_hcnt : '0;
      w_s0.y = w_active ? r_vcnt : '0;
   end
   always_ff @(posedge clk_vga or negedge RST_N)
      if (!RST_N) begin
         r_hcnt <= '0;
         r_vcnt <= '0;
      end else begin
         r_hcnt <= w_eol ? '0 : r_hcnt + 11'd1;
         if (w_eol) r_vcnt <= w_eof ? '0 : r_vcnt + 11'd1;
      end
   // Address = row base + column; both stepped once per 2^S window pixels/lines, so no multiplier.
   always_ff @(posedge clk_vga or negedge RST_N)
      if (!RST_N) begin
         r_col <= '0;
         r_row <= '0;
         r_addr <= '0;
         r_xs <= '0;
         r_ys <= '0;
      end else begin
         if (w_win) begin
            r_addr <= r_row + r_col;
            r_xs <= r_xs == 2'(SUB) ? '0 : r_xs + 2'd1;
            if (r_xs == 2'(SUB)) r_col <= r_col + AW'(1);
         end
         if (w_eol) begin
            r_col <= '0;
            r_xs <= '0;
         end
         if (w_eof) begin
            r_row <= '0;
            r_ys <= '0;
         end else if (w_eol && w_win_row) begin
            r_ys <= r_ys == 2'(SUB) ? '0 : r_ys + 2'd1;
            if (r_ys == 2'(SUB)) r_row <= r_row + AW'(IMG_W);
         end
      end
   vga_delay_line #(.W($bits(side_t)), .D(ROM_LAT + 1)) u_dly (
      .clk_vga(clk_vga),
      .RST_N(RST_N),
      .i_d(w_s0),
      .o_q(w_sd)
   );
`ifdef VGA_TESTBAR_EN
   int         w_bi;
   logic [2:0] w_code;
   logic [CW-1:0] w_bar;
   always_comb begin
      w_bi = int'(w_sd.x) / (H_DISP / 8);
      w_code = BAR_CODE[3'(w_bi > 7 ? 7 : w_bi)];
      w_bar = {{C{w_code[2]}}, {C{w_code[1]}}, {C{w_code[0]}}};
      w_pix = bus.test_en ? w_bar : w_sd.win ? bus.img_data : bus.bg_rgb;
   end
`else
   logic w_unused_test;
   assign w_unused_test = bus.test_en;
   assign w_pix = w_sd.win ? bus.img_data : bus.bg_rgb;
`endif
   assign bus.img_addr = r_addr;
   assign bus.vga_de = w_sd.de;
   assign bus.vga_hsync = HS_POL ? w_sd.hs : !w_sd.hs;
   assign bus.vga_vsync = VS_POL ? w_sd.vs : !w_sd.vs;
   assign bus.vga_rgb = w_sd.de ? w_pix : '0;
   assign bus.pix_x = w_sd.x;
   assign bus.pix_y = w_sd.y;
   assign bus.frame_start = w_sd.fs;
endmodule

// File: tb/tb_vga_scan_engine.sv
// tb_vga_scan_engine: scoreboard bench for two small-raster engines (1:1 window and 2x-scaled window)
module tb_vga_scan_engine;
   import vga_pkg::*;
   typedef struct packed {
      logic        de, hs, vs, fs;
      logic [10:0] x, y;
      logic [11:0] rgb;
   } exp_t;
   localparam rgb_t BARS [8] = '{WHITE, RED, MAGENTA, YELLOW, GREEN, BLUE, CYAN, BLACK};
   logic clk_vga = 1'b0;
   logic RST_N = 1'b0;
   int   checks = 0, errors = 0, n = 0;
   bit   tb_bar = 1'b0;
   exp_t q0[$], q1[$];
   int   hs_r[$], vs_r[$], vs_f[$], fs_r[$];
   logic p_hs = 1'b0, p_vs = 1'b0;
   logic [7:0] r0a = '0, r0b = '0;
   logic [3:0] r1a = '0, r1b = '0;
   vga_scan_engine_if #(.AW(8), .CW(12)) b0 ();
   vga_scan_engine_if #(.AW(4), .CW(12)) b1 ();
   vga_scan_engine #(
      .H_DISP(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3), .V_DISP(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .IMG_X0(4), .IMG_Y0(2), .IMG_W(4), .IMG_H(4), .SCALE_LOG2(0),
      .ROM_LAT(2), .AW(8), .CW(12)
   ) u0 (.clk_vga(clk_vga), .RST_N(RST_N), .bus(b0));
   vga_scan_engine #(
      .H_DISP(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3), .V_DISP(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .HS_POL(1'b0), .VS_POL(1'b1), .IMG_X0(4), .IMG_Y0(2), .IMG_W(2), .IMG_H(2), .SCALE_LOG2(1),
      .ROM_LAT(2), .AW(4), .CW(12)
   ) u1 (.clk_vga(clk_vga), .RST_N(RST_N), .bus(b1));
   always #5 clk_vga = ~clk_vga;
   // ROM models: data = address, two-cycle read latency
   always @(posedge clk_vga) begin
      r0a <= b0.img_addr;
      r0b <= r0a;
      r1a <= b1.img_addr;
      r1b <= r1a;
   end
   assign b0.img_data = 12'(r0b);
   assign b1.img_data = 12'(r1b);
   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      assert (act === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, act, exp);
      end
   endtask
   function automatic int at(input int q[$], input int i);
      return i < q.size() ? q[i] : -1;
   endfunction
   function automatic exp_t idle(input bit s1);
      exp_t e;
      e = '0;
      e.hs = s1;
      return e;
   endfunction
   function automatic exp_t model(input int k, input bit s1);
      exp_t e;
      int   h, v;
      h = k % 24;
      v = (k / 24) % 12;
      e = '0;
      e.de = h < 16 && v < 8;
      e.hs = (h >= 18 && h < 21) ^ s1;
      e.vs = v >= 9 && v < 11;
      e.fs = h == 0 && v == 0;
      if (e.de) begin
         e.x = 11'(h);
         e.y = 11'(v);
         e.rgb = 12'hABC;
         if (tb_bar) e.rgb = BARS[3'(h / 2)];
         else if (h >= 4 && h < 8 && v >= 2 && v < 6)
            e.rgb = s1 ? 12'(((v - 2) / 2) * 2 + (h - 4) / 2) : 12'((v - 2) * 4 + h - 4);
      end
      return e;
   endfunction
   task automatic sb_init();
      q0.delete();
      q1.delete();
      hs_r.delete();
      vs_r.delete();
      vs_f.delete();
      fs_r.delete();
      repeat (3) begin
         q0.push_back(idle(1'b0));
         q1.push_back(idle(1'b1));
      end
      n = 0;
      p_hs = 1'b0;
      p_vs = 1'b0;
   endtask
   task automatic sample();
      exp_t a0, a1;
      q0.push_back(model(n, 1'b0));
      q1.push_back(model(n, 1'b1));
      a0 = '{b0.vga_de, b0.vga_hsync, b0.vga_vsync, b0.frame_start, b0.pix_x, b0.pix_y, b0.vga_rgb};
      a1 = '{b1.vga_de, b1.vga_hsync, b1.vga_vsync, b1.frame_start, b1.pix_x, b1.pix_y, b1.vga_rgb};
      chk($sformatf("sb0 n=%0d", n), 64'(a0), 64'(q0.pop_front()));
      chk($sformatf("sb1 n=%0d", n), 64'(a1), 64'(q1.pop_front()));
      chk($sformatf("addr1_max n=%0d", n), 64'(b1.img_addr <= 4'd3), 64'd1);
      if (a0.hs && !p_hs) hs_r.push_back(n);
      if (a0.vs && !p_vs) vs_r.push_back(n);
      if (!a0.vs && p_vs) vs_f.push_back(n);
      if (a0.fs) fs_r.push_back(n);
      p_hs = a0.hs;
      p_vs = a0.vs;
      n++;
   endtask
   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         sample();
         @(negedge clk_vga);
      end
   endtask
   initial begin
      b0.bg_rgb = 12'hABC;
      b1.bg_rgb = 12'hABC;
      b0.test_en = 1'b0;
      b1.test_en = 1'b0;
      repeat (3) @(negedge clk_vga);
      chk("rst_de", 64'(b0.vga_de), 64'd0);
      chk("rst_hs0", 64'(b0.vga_hsync), 64'd0);
      chk("rst_hs1_lowpol", 64'(b1.vga_hsync), 64'd1);
      chk("rst_addr", 64'(b0.img_addr), 64'd0);
      RST_N = 1'b1;
      sb_init();
      run(82);
      sample();
      #1 RST_N = 1'b0;
      #1;
      chk("mid_de", 64'(b0.vga_de), 64'd0);
      chk("mid_rgb", 64'(b0.vga_rgb), 64'd0);
      chk("mid_pix", 64'({b0.pix_x, b0.pix_y}), 64'd0);
      chk("mid_sync", 64'({b0.vga_hsync, b0.vga_vsync, b1.vga_hsync}), 64'b001);
      chk("mid_fs", 64'(b0.frame_start), 64'd0);
      chk("mid_addr", 64'({b0.img_addr, b1.img_addr}), 64'd0);
      chk("hs_first", 64'(at(hs_r, 0)), 64'd21);
      chk("hs_period", 64'(at(hs_r, 1) - at(hs_r, 0)), 64'd24);
`ifdef VGA_TESTBAR_EN
      b0.test_en = 1'b1;
      b1.test_en = 1'b1;
      tb_bar = 1'b1;
`endif
      repeat (4) @(negedge clk_vga);
      RST_N = 1'b1;
      sb_init();
      run(586);
      chk("fs_first", 64'(at(fs_r, 0)), 64'd3);
      chk("fs_period", 64'(at(fs_r, 1) - at(fs_r, 0)), 64'd288);
      chk("hs_first2", 64'(at(hs_r, 0)), 64'd21);
      chk("vs_first", 64'(at(vs_r, 0)), 64'd219);
      chk("vs_width", 64'(at(vs_f, 0) - at(vs_r, 0)), 64'd48);
      chk("vs_period", 64'(at(vs_r, 1) - at(vs_r, 0)), 64'd288);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
